data_mem_responder: RTL and testbench

Memory-side responder for the CPU's data-memory port: accepts one load or store request at a time over a valid/ready handshake. It models a configurable number of wait states, then returns one response beat. It also drives a `stall` output that the CPU uses to hold the PC and pipeline while an access is outstanding. It sits between the CPU datapath (ALU result as address, register B as store data) and the data storage array, replacing the zero-latency DataMemory.

---
 rtl/data_mem_responder.sv | 207 ++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: data-memory responder with a valid/ready request
// handshake. After LATENCY wait states it returns one response beat, and it
// drives a CPU stall while an access is outstanding.
// Optional feature: define DMEM_ALIGN_CHECK_EN to fault accesses whose byte
// address is not 8-byte aligned (the store is suppressed, the load data is
// zero and resp_err is raised). When the macro is undefined, the low address
// bits are ignored and resp_err is tied low.
`timescale 1ns/1ps

module data_mem_responder #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned LATENCY    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic        stall
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
   localparam bit ZERO_LAT = (LATENCY == 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic [3:0]              cnt_q;

   // Request captured at accept and used by a delayed commit
   logic                    wr_q;
   logic [ADDR_WIDTH-1:0]   idx_q;
   logic [63:0]             wdata_q;

   // Commit controls, taken from the live request (zero latency) or the latch
   logic                    commit_en;
   logic                    c_write;
   logic [ADDR_WIDTH-1:0]   c_idx;
   logic [63:0]             c_wdata;
   logic                    c_err;

   logic [ADDR_WIDTH-1:0]   req_idx;
   logic                    accept;

   logic [63:0]             mem [DEPTH];

   logic [63:0]             rdata_q;
   logic                    err_q;

   // High address bits above the word index alias (wrap) and are never used
   logic                    unused_addr_bits;

   assign req_idx          = req_addr[ADDR_WIDTH+2:3];
   assign accept           = (state_q == IDLE) && req_valid;
   assign unused_addr_bits = ^{req_addr[63:ADDR_WIDTH+3], req_addr[2:0]};

`ifdef DMEM_ALIGN_CHECK_EN
   logic                    mis_q;
   logic                    req_mis;

   assign req_mis = (req_addr[2:0] != 3'd0);

   // Capture the alignment fault at accept so that it travels with the access
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mis_q <= 1'b0;
      end else if (accept) begin
         mis_q <= req_mis;
      end
   end
`endif

   // State register and wait counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cnt_q <= CNT_LOAD;
         end else if ((state_q == WAIT) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 4'd1;
         end
      end
   end

   // Next-state logic: IDLE -> (WAIT ->)* RESP -> IDLE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d = ZERO_LAT ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Handshake and stall outputs decoded from the current state
   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      stall      = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            stall     = req_valid;
         end
         WAIT: begin
            stall = 1'b1;
         end
         RESP: begin
            resp_valid = 1'b1;
         end
         default: begin
            req_ready = 1'b0;
         end
      endcase
   end

   // Latch the accepted request for a commit that happens after wait states
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         wr_q    <= req_write;
         idx_q   <= req_idx;
         wdata_q <= req_wdata;
      end
   end

   // Commit selection; a zero-latency access commits straight from the request
   // and nothing commits while reset is held
   always_comb begin
      commit_en = 1'b0;
      c_write   = wr_q;
      c_idx     = idx_q;
      c_wdata   = wdata_q;
`ifdef DMEM_ALIGN_CHECK_EN
      c_err     = mis_q;
`else
      c_err     = 1'b0;
`endif
      if (ZERO_LAT && accept) begin
         commit_en = 1'b1;
         c_write   = req_write;
         c_idx     = req_idx;
         c_wdata   = req_wdata;
`ifdef DMEM_ALIGN_CHECK_EN
         c_err     = req_mis;
`endif
      end else if ((state_q == WAIT) && (cnt_q == '0)) begin
         commit_en = 1'b1;
      end
      if (reset) begin
         commit_en = 1'b0;
      end
   end

   // Storage array: not reset; a faulted store is suppressed
   always_ff @(posedge clk) begin
      if (commit_en && c_write && !c_err) begin
         mem[c_idx] <= c_wdata;
      end
   end

   // Response registers: loaded at commit, cleared on every other edge so they
   // read zero outside RESP
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         rdata_q <= (commit_en && !c_write && !c_err) ? mem[c_idx] : '0;
         err_q   <= commit_en && c_err;
      end
   end

   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: self-checking bench for data_mem_responder with a
// word-addressed reference memory and a cycle-position timing expectation.
`timescale 1ns/1ps

module tb_data_mem_responder;

   localparam int unsigned AW    = 8;
   localparam int unsigned LAT   = 3;
   localparam int unsigned DEPTH = 1 << AW;
   localparam int unsigned PER   = LAT + 2;
`ifdef DMEM_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_write;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic        stall;

   int checks   = 0;
   int failures = 0;

   logic [63:0] ref_mem [DEPTH];
   bit          known   [DEPTH];

   always #5 clk = ~clk;

   data_mem_responder #(
      .ADDR_WIDTH (AW),
      .LATENCY    (LAT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .stall      (stall)
   );

   function automatic int unsigned word_of(input logic [63:0] a);
      return int'((a >> 3) % 64'(DEPTH));
   endfunction

   // One complete access with cycle-by-cycle expectations
   task automatic access(input bit wr, input logic [63:0] addr, input logic [63:0] wdata,
                         input string tag);
      int unsigned w;
      bit          exp_err;
      bit          chk_rd;
      logic [63:0] exp_rd;
      w       = word_of(addr);
      exp_err = ALIGN && (addr[2:0] != 3'd0);
      chk_rd  = 1'b1;
      exp_rd  = '0;
      if (!wr && !exp_err) begin
         if (known[w]) exp_rd = ref_mem[w];
         else chk_rd = 1'b0;
      end
      if (wr && !exp_err) begin
         ref_mem[w] = wdata;
         known[w]   = 1'b1;
      end

      @(negedge clk);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      #1;
      checks++;
      if ({req_ready, resp_valid, stall} !== 3'b101)
         begin failures++; $display("FAIL %s_request: ready/valid/stall=%b expected 101", tag, {req_ready, resp_valid, stall}); end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom};
      #1;
      for (int i = 0; i < int'(LAT); i++) begin
         checks++;
         if ({req_ready, resp_valid, stall} !== 3'b001)
            begin failures++; $display("FAIL %s_wait%0d: ready/valid/stall=%b expected 001", tag, i, {req_ready, resp_valid, stall}); end
         @(negedge clk);
         #1;
      end
      checks++;
      if ({req_ready, resp_valid, stall} !== 3'b010)
         begin failures++; $display("FAIL %s_resp: ready/valid/stall=%b expected 010", tag, {req_ready, resp_valid, stall}); end
      checks++;
      if (resp_err !== exp_err)
         begin failures++; $display("FAIL %s_err: got %b expected %b", tag, resp_err, exp_err); end
      if (chk_rd) begin
         checks++;
         if (resp_rdata !== exp_rd)
            begin failures++; $display("FAIL %s_rdata: got %h expected %h", tag, resp_rdata, exp_rd); end
      end
      @(negedge clk);
      #1;
      checks++;
      if ({req_ready, resp_valid, stall, resp_err, resp_rdata} !== {4'b1000, 64'd0})
         begin failures++; $display("FAIL %s_after: ready/valid/stall/err=%b rdata=%h expected 1000 and 0", tag, {req_ready, resp_valid, stall, resp_err}, resp_rdata); end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if ({req_ready, resp_valid, stall, resp_err} !== 4'b1000)
         begin failures++; $display("FAIL reset_outputs: ready/valid/stall/err=%b expected 1000", {req_ready, resp_valid, stall, resp_err}); end
      checks++;
      if (resp_rdata !== 64'd0)
         begin failures++; $display("FAIL reset_rdata: got %h expected 0", resp_rdata); end
      req_valid = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b1)
         begin failures++; $display("FAIL reset_stall_follows_valid: got %b expected 1", stall); end
      @(negedge clk);
      #1;
      checks++;
      if ({req_ready, resp_valid, stall} !== 3'b101)
         begin failures++; $display("FAIL reset_no_accept: ready/valid/stall=%b expected 101", {req_ready, resp_valid, stall}); end
      req_valid = 1'b0;
      reset     = 1'b0;
   endtask

   task automatic test_store_load();
      access(1'b1, 64'h10, 64'h1122334455667788, "store_10");
      access(1'b0, 64'h10, 64'h0, "load_10");
   endtask

   task automatic test_reset_mid_access();
      access(1'b1, 64'h20, 64'hAAAA, "prestore_20");
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 64'h20;
      req_wdata = 64'hDEADBEEF;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({req_ready, resp_valid, stall} !== 3'b100)
         begin failures++; $display("FAIL midreset_forced_idle: ready/valid/stall=%b expected 100", {req_ready, resp_valid, stall}); end
      for (int i = 0; i < int'(PER); i++) begin
         @(negedge clk);
         #1;
         checks++;
         if (resp_valid !== 1'b0)
            begin failures++; $display("FAIL midreset_no_resp%0d: resp_valid=%b expected 0", i, resp_valid); end
      end
      reset = 1'b0;
      access(1'b0, 64'h20, 64'h0, "midreset_load_20");
   endtask

   task automatic test_misaligned();
      access(1'b1, 64'h08, {$urandom, $urandom}, "mis_prestore_08");
      access(1'b1, 64'h0C, 64'h55, "mis_store_0c");
      access(1'b0, 64'h08, 64'h0, "mis_load_08");
      access(1'b0, 64'h0D, 64'h0, "mis_load_0d");
   endtask

   task automatic test_wrap();
      access(1'b1, 64'h808, 64'h77, "wrap_store_808");
      access(1'b0, 64'h008, 64'h0, "wrap_load_008");
   endtask

   task automatic test_back_to_back_held();
      int unsigned ph;
      access(1'b1, 64'h30, 64'h0123456789ABCDEF, "held_prestore_30");
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 64'h30;
      #1;
      for (int k = 0; k < int'(3 * PER); k++) begin
         ph = k % PER;
         if (ph == 0) begin
            checks++;
            if ({req_ready, resp_valid, stall} !== 3'b101)
               begin failures++; $display("FAIL held_idle%0d: ready/valid/stall=%b expected 101", k, {req_ready, resp_valid, stall}); end
         end else if (ph <= LAT) begin
            checks++;
            if ({req_ready, resp_valid, stall} !== 3'b001)
               begin failures++; $display("FAIL held_wait%0d: ready/valid/stall=%b expected 001", k, {req_ready, resp_valid, stall}); end
         end else begin
            checks++;
            if ({req_ready, resp_valid, stall} !== 3'b010)
               begin failures++; $display("FAIL held_resp%0d: ready/valid/stall=%b expected 010", k, {req_ready, resp_valid, stall}); end
            checks++;
            if (resp_rdata !== ref_mem[word_of(64'h30)])
               begin failures++; $display("FAIL held_rdata%0d: got %h expected %h", k, resp_rdata, ref_mem[word_of(64'h30)]); end
         end
         @(negedge clk);
         #1;
      end
      req_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [63:0] a;
      int unsigned w;
      for (int i = 0; i < 16; i++)
         access(1'b1, 64'(i) << 3, {$urandom, $urandom}, "rnd_fill");
      for (int i = 0; i < 40; i++) begin
         w = $urandom % 16;
         a = ({$urandom, $urandom} << (AW + 3)) | (64'(w) << 3);
         if ($urandom % 4 == 0) a = a | 64'($urandom % 8);
         access(1'($urandom), a, {$urandom, $urandom}, "rnd");
      end
   endtask

   initial begin
      for (int i = 0; i < int'(DEPTH); i++) known[i] = 1'b0;
      test_reset();
      test_store_load();
      test_reset_mid_access();
      test_misaligned();
      test_wrap();
      test_back_to_back_held();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
